alu_exec_stage: RTL and testbench

- Execute stage directly downstream of ALU-op decode. Consumes the 4-bit ALU opcode plus two operands and a destination register index; produces a registered result toward writeback.
- valid/ready handshake on both sides. Logical/arithmetic ops complete in 1 cycle. Shifts run on an iterative shifter, 1 bit per cycle.
- Adds shift and compare opcodes alongside ADD/SUB/AND/OR/XOR.

---
 rtl/rv32i_pkg.sv | 35 +++
 rtl/alu_shift_unit.sv | 63 ++++++
 rtl/alu_exec_stage.sv | 162 ++++++++++++++++
 tb/tb_alu_exec_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I execute definitions: ALU opcodes, default widths and execute-stage state encodings.
package rv32i_pkg;

  localparam int XLEN_DEFAULT    = 32;
  localparam int RADDR_W_DEFAULT = 5;
  localparam int SHAMT_W         = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_FULL  = 2'b10
  } exec_state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } shift_type_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Iterative shifter, one bit per cycle. done is high in the cycle whose result output
// holds the final shifted value; a start with shamt=0 never goes busy.
module alu_shift_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               start,
  input  shift_type_e        sh_type,
  input  logic [XLEN-1:0]    data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result
);

  logic [XLEN-1:0]    data_r;
  logic [XLEN-1:0]    shifted_s;
  logic [SHAMT_W-1:0] cnt_r;
  shift_type_e        type_r;
  logic               busy_r;

  // one-bit shift of the working value
  always_comb begin
    shifted_s = data_r;
    case (type_r)
      SH_SLL:  shifted_s = {data_r[XLEN-2:0], 1'b0};
      SH_SRL:  shifted_s = {1'b0, data_r[XLEN-1:1]};
      SH_SRA:  shifted_s = {data_r[XLEN-1], data_r[XLEN-1:1]};
      default: shifted_s = data_r;
    endcase
  end

  assign busy   = busy_r;
  assign done   = busy_r && (cnt_r == 5'd1);
  assign result = shifted_s;

  // working value and remaining-count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= {XLEN{1'b0}};
      cnt_r  <= 5'd0;
      type_r <= SH_SLL;
      busy_r <= 1'b0;
    end else if (flush) begin
      cnt_r  <= 5'd0;
      busy_r <= 1'b0;
    end else if (start) begin
      data_r <= data_in;
      cnt_r  <= shamt;
      type_r <= sh_type;
      busy_r <= (shamt != 5'd0);
    end else if (busy_r) begin
      data_r <= shifted_s;
      cnt_r  <= cnt_r - 5'd1;
      busy_r <= (cnt_r != 5'd1);
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage with valid/ready on both sides and a registered result toward writeback.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN    = XLEN_DEFAULT,
  parameter int RADDR_W = RADDR_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  input  logic [RADDR_W-1:0] rd_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic [RADDR_W-1:0] rd_out,
  output logic               zero
);

  exec_state_e        state_r, state_n_s;
  logic               accept_s;
  logic               long_shift_s;
  logic               sh_done_s;
  logic               sh_busy_s;
  logic               load_s;
  logic [XLEN-1:0]    load_val_s;
  logic [RADDR_W-1:0] load_rd_s;
  logic [XLEN-1:0]    alu_res_s;
  logic [SHAMT_W-1:0] shamt_s;

  assign shamt_s   = op_b[SHAMT_W-1:0];
  assign in_ready  = !rst && !flush &&
                     ((state_r == ST_IDLE) || ((state_r == ST_FULL) && out_ready));
  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == ST_FULL);

  // single-cycle ALU; shifts are resolved here only in the barrel build or when shamt is 0
  always_comb begin
    alu_res_s = op_a + op_b;
    case (alu_op)
      ALU_ADD:  alu_res_s = op_a + op_b;
      ALU_SUB:  alu_res_s = op_a - op_b;
      ALU_AND:  alu_res_s = op_a & op_b;
      ALU_OR:   alu_res_s = op_a | op_b;
      ALU_XOR:  alu_res_s = op_a ^ op_b;
`ifdef ALU_FAST_SHIFT_EN
      ALU_SLL:  alu_res_s = op_a << shamt_s;
      ALU_SRL:  alu_res_s = op_a >> shamt_s;
      ALU_SRA:  alu_res_s = $signed(op_a) >>> shamt_s;
`else
      ALU_SLL:  alu_res_s = op_a;
      ALU_SRL:  alu_res_s = op_a;
      ALU_SRA:  alu_res_s = op_a;
`endif
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  alu_res_s = op_a + op_b;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign long_shift_s = 1'b0;
  assign sh_done_s    = 1'b0;
  assign sh_busy_s    = 1'b0;
  assign load_s       = accept_s;
  assign load_val_s   = alu_res_s;
  assign load_rd_s    = rd_in;
`else
  shift_type_e        sh_type_s;
  logic [XLEN-1:0]    sh_res_s;
  logic [RADDR_W-1:0] rd_pend_r;

  assign long_shift_s = is_shift_op(alu_op) && (shamt_s != 5'd0);
  // a shift completing in a flush cycle is abandoned, never written back
  assign load_s       = (accept_s && !long_shift_s) || (sh_done_s && !flush);
  assign load_val_s   = sh_done_s ? sh_res_s : alu_res_s;
  assign load_rd_s    = sh_done_s ? rd_pend_r : rd_in;

  // opcode to shift direction
  always_comb begin
    sh_type_s = SH_SLL;
    case (alu_op)
      ALU_SRL: sh_type_s = SH_SRL;
      ALU_SRA: sh_type_s = SH_SRA;
      default: sh_type_s = SH_SLL;
    endcase
  end

  // destination index held while the shifter iterates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_r <= {RADDR_W{1'b0}};
    end else if (accept_s) begin
      rd_pend_r <= rd_in;
    end
  end

  alu_shift_unit #(.XLEN(XLEN)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .start   (accept_s && long_shift_s),
    .sh_type (sh_type_s),
    .data_in (op_a),
    .shamt   (shamt_s),
    .busy    (sh_busy_s),
    .done    (sh_done_s),
    .result  (sh_res_s)
  );
`endif

  // next-state logic; flush overrides everything
  always_comb begin
    state_n_s = state_r;
    if (flush) begin
      state_n_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_n_s = long_shift_s ? ST_SHIFT : ST_FULL;
          else          state_n_s = ST_IDLE;
        end
        ST_SHIFT: begin
          if (sh_done_s)       state_n_s = ST_FULL;
          else if (!sh_busy_s) state_n_s = ST_IDLE;
          else                 state_n_s = ST_SHIFT;
        end
        ST_FULL: begin
          if (accept_s)       state_n_s = long_shift_s ? ST_SHIFT : ST_FULL;
          else if (out_ready) state_n_s = ST_IDLE;
          else                state_n_s = ST_FULL;
        end
        default: state_n_s = ST_IDLE;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_n_s;
  end

  // output register; holds while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= {XLEN{1'b0}};
      rd_out <= {RADDR_W{1'b0}};
      zero   <= 1'b0;
    end else if (load_s) begin
      result <= load_val_s;
      rd_out <= load_rd_s;
      zero   <= (load_val_s == {XLEN{1'b0}});
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed self-checking bench for alu_exec_stage (default and ALU_FAST_SHIFT_EN builds).
module tb_alu_exec_stage;
  import rv32i_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, zero;
  logic [3:0]  alu_op;
  logic [31:0] op_a, op_b, result;
  logic [4:0]  rd_in, rd_out;
  int vectors = 0;
  int miscompares = 0;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_exec_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .rd_out(rd_out), .zero(zero)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    in_valid = 1'b1; alu_op = op; op_a = a; op_b = b; rd_in = rd;
  endtask

  task automatic test_reset();
    tick(); tick(); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
    vectors++; if (rd_out !== 5'd0) begin miscompares++; $display("FAIL reset_rd_out: got %0d expected 0", rd_out); end
    vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL reset_zero: got %b expected 0", zero); end
    rst = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_add_wrap();
    tick(); drive(ALU_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5); out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL add_in_ready: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL add_result: got %h expected 00000000", result); end
    vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL add_zero: got %b expected 1", zero); end
    vectors++; if (rd_out !== 5'd5) begin miscompares++; $display("FAIL add_rd_out: got %0d expected 5", rd_out); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    tick(); drive(ALU_SUB, 32'd5, 32'd7, 5'd1); out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready0: got %b expected 1", in_ready); end
    tick();
    vectors++; if (result !== 32'hFFFF_FFFE || out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_sub: got %h/%b expected fffffffe/1", result, out_valid); end
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'h1, 5'd2); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready1: got %b expected 1", in_ready); end
    tick();
    vectors++; if (result !== 32'h1 || rd_out !== 5'd2) begin miscompares++; $display("FAIL b2b_slt: got %h rd %0d expected 00000001 rd 2", result, rd_out); end
    drive(ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd3); #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready2: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (result !== 32'h0 || zero !== 1'b1 || rd_out !== 5'd3) begin miscompares++; $display("FAIL b2b_sltu: got %h z%b rd %0d expected 00000000 z1 rd 3", result, zero, rd_out); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_shift();
    logic [3:0]  ops [3];
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] ev [3];
    int          lv [3];
    int          n;
    bit          ready_bad;
    ops = '{ALU_SRA, ALU_SLL, ALU_SRL};
    av  = '{32'h8000_0000, 32'h1234_5678, 32'h8000_0000};
    bv  = '{32'd4, 32'd32, 32'd31};
    ev  = '{32'hF800_0000, 32'h1234_5678, 32'h0000_0001};
    lv  = '{FAST ? 1 : 5, 1, FAST ? 1 : 32};
    for (int i = 0; i < 3; i++) begin
      tick(); drive(ops[i], av[i], bv[i], 5'(i + 7)); out_ready = 1'b1; #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL shift%0d_accept: got %b expected 1", i, in_ready); end
      n = 0; ready_bad = 1'b0;
      do begin
        tick(); n++;
        if (n == 1) in_valid = 1'b0;
        if (!out_valid && in_ready) ready_bad = 1'b1;
      end while (!out_valid && n < 40);
      vectors++; if (n != lv[i]) begin miscompares++; $display("FAIL shift%0d_latency: got %0d expected %0d", i, n, lv[i]); end
      vectors++; if (result !== ev[i]) begin miscompares++; $display("FAIL shift%0d_result: got %h expected %h", i, result, ev[i]); end
      vectors++; if (rd_out !== 5'(i + 7)) begin miscompares++; $display("FAIL shift%0d_rd: got %0d expected %0d", i, rd_out, i + 7); end
      vectors++; if (ready_bad) begin miscompares++; $display("FAIL shift%0d_busy_ready: got 1 expected 0", i); end
      tick();
    end
  endtask

  task automatic test_stall();
    tick(); drive(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd10); out_ready = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_accept: got %b expected 1", in_ready); end
    tick(); drive(ALU_OR, 32'd1, 32'd2, 5'd11);
    for (int k = 0; k < 3; k++) begin
      vectors++; if (out_valid !== 1'b1 || result !== 32'h0000_00F0 || rd_out !== 5'd10) begin miscompares++; $display("FAIL stall_hold%0d: got %b %h rd %0d expected 1 000000f0 rd 10", k, out_valid, result, rd_out); end
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready%0d: got %b expected 0", k, in_ready); end
      tick();
    end
    out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b expected 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || result !== 32'h3 || rd_out !== 5'd11) begin miscompares++; $display("FAIL stall_next: got %b %h rd %0d expected 1 00000003 rd 11", out_valid, result, rd_out); end
    tick();
  endtask

  task automatic test_flush();
    bit seen;
    tick(); drive(ALU_SLL, 32'h1, 32'd20, 5'd3); out_ready = FAST ? 1'b0 : 1'b1;
    tick(); in_valid = 1'b0;
    if (FAST) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_pre_valid: got %b expected 1", out_valid); end
    end else begin
      repeat (9) tick();
    end
    flush = 1'b1; drive(ALU_ADD, 32'd2, 32'd3, 5'd4); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL flush_out_valid: got 1 expected 0"); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_idle: got %b expected 1", in_ready); end
    drive(ALU_ADD, 32'd2, 32'd3, 5'd4);
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || result !== 32'd5 || rd_out !== 5'd4) begin miscompares++; $display("FAIL flush_next_add: got %b %h rd %0d expected 1 00000005 rd 4", out_valid, result, rd_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    tick(); drive(ALU_SRL, 32'hFFFF_FFFF, 32'd10, 5'd6); out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    tick(); tick();
    #2 rst = 1'b1; #1;
    vectors++; if (out_valid !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0) begin miscompares++; $display("FAIL rst_shift: got %b %h rd %0d expected 0 00000000 rd 0", out_valid, result, rd_out); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_shift_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    vectors++; if (seen) begin miscompares++; $display("FAIL rst_shift_partial: got 1 expected 0"); end
    drive(ALU_XOR, 32'h0000_00A5, 32'h0000_000F, 5'd2); out_ready = 1'b0;
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || result !== 32'h0000_00AA) begin miscompares++; $display("FAIL rst_full_pre: got %b %h expected 1 000000aa", out_valid, result); end
    #2 rst = 1'b1; #1;
    vectors++; if (out_valid !== 1'b0 || result !== 32'h0 || rd_out !== 5'd0 || zero !== 1'b0) begin miscompares++; $display("FAIL rst_full: got %b %h rd %0d z%b expected 0 00000000 rd 0 z0", out_valid, result, rd_out, zero); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_default_op();
    logic [3:0] bad_op;
    bad_op = 4'b1111;
    tick(); drive(bad_op, 32'd10, 32'd20, 5'd1); out_ready = 1'b1;
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || result !== 32'd30 || rd_out !== 5'd1) begin miscompares++; $display("FAIL default_op: got %b %h rd %0d expected 1 0000001e rd 1", out_valid, result, rd_out); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 4'b0000; op_a = 32'h0; op_b = 32'h0; rd_in = 5'd0;
    test_reset();
    test_add_wrap();
    test_back_to_back();
    test_shift();
    test_stall();
    test_flush();
    test_reset_mid();
    test_default_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
